// File: rtl/mem_bus_decoder.sv
// Bridges the picorv32 native memory port to one RAM controller and one IO port.
// Each request is registered, decoded, handed to one slave, and answered with a registered response.
module mem_bus_decoder #(
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE = 32'h0002_0000,
    parameter logic [31:0] IO_BASE  = 32'h1000_0000,
    parameter logic [31:0] IO_SIZE  = 32'h0000_1000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [3:0]  cpu_mem_wstrb,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        ram_enable,
    output logic        ram_valid,
    output logic        ram_instr,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        io_valid,
    output logic [3:0]  io_wstrb,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic        bus_error,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {TGT_RAM, TGT_IO, TGT_ERR} target_t;

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_nxt;
    target_t          target_q, target_d;
    logic [31:0]      addr_q, wdata_q, rdata_q, err_addr_q;
    logic [3:0]       wstrb_q;
    logic             instr_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       err_count_q, err_count_inc;
    logic             in_ram, in_io, slave_ready, timeout_hit;
    logic [31:0]      slave_rdata;

    // Offset compare wraps below BASE and cannot overflow when BASE+SIZE = 2^32.
    assign in_ram = (cpu_mem_addr - RAM_BASE) < RAM_SIZE;
    assign in_io  = (cpu_mem_addr - IO_BASE) < IO_SIZE;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        target_d = TGT_ERR;
        if (in_ram)
            target_d = TGT_RAM;
        else if (in_io && !cpu_mem_instr)
            target_d = TGT_IO;
    end

    always_comb begin
        slave_ready = 1'b0;
        slave_rdata = '0;
        if (target_q == TGT_RAM) begin
            slave_ready = ram_ready;
            slave_rdata = ram_rdata;
        end else if (target_q == TGT_IO) begin
            slave_ready = io_ready;
            slave_rdata = io_rdata;
        end
    end

    assign timeout_hit   = (cnt_q == CNT_LAST);
    assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (cpu_mem_valid) state_nxt = (target_d == TGT_ERR) ? RESP : ACCESS;
            ACCESS:  if (slave_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    // NOTE: only control and datapath registers here; reset is synchronous, so it takes effect on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q    <= TGT_ERR;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            instr_q     <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (cpu_mem_valid) begin
                    addr_q   <= cpu_mem_addr;
                    wstrb_q  <= cpu_mem_wstrb;
                    wdata_q  <= cpu_mem_wdata;
                    instr_q  <= cpu_mem_instr;
                    target_q <= target_d;
                    cnt_q    <= '0;
                    rdata_q  <= '0;
                    err_q    <= (target_d == TGT_ERR);
                    if (target_d == TGT_ERR) begin
                        err_addr_q  <= cpu_mem_addr;
                        err_count_q <= err_count_inc;
                    end
                end
                ACCESS: begin
                    // Ready on the last counted cycle still wins over the timeout.
                    if (slave_ready) begin
                        rdata_q <= (wstrb_q == 4'b0000) ? slave_rdata : '0;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        err_addr_q  <= addr_q;
                        err_count_q <= err_count_inc;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_mem_ready = (state_q == RESP);
    assign cpu_mem_rdata = rdata_q;
    assign bus_error     = (state_q == RESP) && err_q;
    assign err_addr      = err_addr_q;
    assign err_count     = err_count_q;

    // The RAM writes on any nonzero strobe, so strobes are gated by the select.
    assign ram_enable = (state_q == ACCESS) && (target_q == TGT_RAM);
    assign ram_valid  = ram_enable;
    assign ram_instr  = instr_q;
    assign ram_wstrb  = ram_enable ? wstrb_q : 4'b0000;
    assign ram_addr   = addr_q - RAM_BASE;
    assign ram_wdata  = wdata_q;

    assign io_valid = (state_q == ACCESS) && (target_q == TGT_IO);
    assign io_wstrb = io_valid ? wstrb_q : 4'b0000;
    assign io_addr  = addr_q - IO_BASE;
    assign io_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed self-checking bench for mem_bus_decoder with a registered RAM model and a latency-programmable IO slave.
module tb_mem_bus_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mem_valid = 1'b0;
    logic        cpu_mem_instr = 1'b0;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic [31:0] cpu_mem_addr = '0;
    logic [31:0] cpu_mem_wdata = '0;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        ram_enable, ram_valid, ram_instr;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_addr, ram_wdata;
    logic        ram_ready = 1'b0;
    logic [31:0] ram_rdata;
    logic        io_valid;
    logic [3:0]  io_wstrb;
    logic [31:0] io_addr, io_wdata;
    logic        io_ready;
    logic [31:0] io_rdata;
    logic        bus_error;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram_word = '0;
    int          io_lat = -1;
    int          io_cnt = 0;
    logic        io_stray = 1'b0;
    int          wstrb_nz_cycles = 0;

    int          r_cyc, r_ready_n;
    logic [31:0] r_rdata, r_ram_addr, r_io_addr;
    logic        r_err, r_seen_ram, r_seen_io;

    mem_bus_decoder #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .ram_enable(ram_enable), .ram_valid(ram_valid), .ram_instr(ram_instr),
        .ram_wstrb(ram_wstrb), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .io_valid(io_valid), .io_wstrb(io_wstrb), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_ready(io_ready), .io_rdata(io_rdata),
        .bus_error(bus_error), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Registered RAM: ready follows valid by one cycle.
    always @(posedge clk) ram_ready <= reset ? 1'b0 : ram_valid;
    assign ram_rdata = ram_word;

    always @(posedge clk) io_cnt <= io_valid ? io_cnt + 1 : 0;
    always_comb io_ready = (io_valid && io_lat >= 0 && io_cnt == io_lat) || io_stray;
    assign io_rdata = 32'hCAFE_0004;

    always @(negedge clk) if (ram_wstrb != 4'b0000) wstrb_nz_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in IDLE and records the response; cycle 0 is the sampling edge.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic instr);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = addr;
        cpu_mem_wstrb = wstrb;
        cpu_mem_wdata = wdata;
        cpu_mem_instr = instr;
        step();
        cpu_mem_valid = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wstrb = '0;
        cpu_mem_wdata = '0;
        cpu_mem_instr = 1'b0;
        r_cyc = -1; r_ready_n = 0; r_rdata = 'x; r_err = 1'bx;
        r_seen_ram = 1'b0; r_seen_io = 1'b0; r_ram_addr = 'x; r_io_addr = 'x;
        for (int c = 1; c <= 60; c++) begin
            if (ram_valid && !r_seen_ram) begin r_seen_ram = 1'b1; r_ram_addr = ram_addr; end
            if (io_valid && !r_seen_io) begin r_seen_io = 1'b1; r_io_addr = io_addr; end
            if (cpu_mem_ready) begin
                r_ready_n++;
                if (r_cyc < 0) begin r_cyc = c; r_rdata = cpu_mem_rdata; r_err = bus_error; end
            end
            if (r_cyc >= 0 && c >= r_cyc + 1) break;
            step();
        end
    endtask

    initial begin
        repeat (3) step();
        check("rst_ready", cpu_mem_ready, 0);
        check("rst_ram_en", ram_enable, 0);
        check("rst_ram_valid", ram_valid, 0);
        check("rst_io_valid", io_valid, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_rdata", cpu_mem_rdata, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_addr", err_addr, 0);
        reset = 1'b0;
        step();

        // RAM read, registered RAM: ready at cycle 3.
        ram_word = 32'h1234_5678;
        run_txn(32'h0000_0010, 4'b0000, 32'h0, 1'b0);
        check("ram_rd_cycle", r_cyc, 3);
        check("ram_rd_data", r_rdata, 32'h1234_5678);
        check("ram_rd_err", r_err, 0);
        check("ram_rd_addr", r_ram_addr, 32'h10);
        check("ram_rd_io_seen", r_seen_io, 0);
        check("ram_rd_pulses", r_ready_n, 1);

        // RAM write: strobes only during the two ACCESS cycles, rdata 0.
        ram_word = 32'hFFFF_FFFF;
        run_txn(32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 1'b0);
        check("ram_wr_cycle", r_cyc, 3);
        check("ram_wr_data", r_rdata, 32'h0);
        check("ram_wr_pulses", r_ready_n, 1);
        check("ram_wr_strb_cycles", wstrb_nz_cycles, 2);

        // Stray IO ready must not end a RAM access.
        ram_word = 32'h0BAD_F00D;
        io_stray = 1'b1;
        run_txn(32'h0000_0100, 4'b0000, 32'h0, 1'b0);
        io_stray = 1'b0;
        check("stray_cycle", r_cyc, 3);
        check("stray_data", r_rdata, 32'h0BAD_F00D);

        // IO read with ready held low for 5 cycles.
        io_lat = 5;
        run_txn(32'h1000_0004, 4'b0000, 32'h0, 1'b0);
        check("io_rd_cycle", r_cyc, 7);
        check("io_rd_addr", r_io_addr, 32'h4);
        check("io_rd_data", r_rdata, 32'hCAFE_0004);
        check("io_rd_ram_seen", r_seen_ram, 0);

        // Unmapped read, then IO fetch: immediate errors.
        run_txn(32'h2000_0000, 4'b0000, 32'h0, 1'b0);
        check("unmap_cycle", r_cyc, 1);
        check("unmap_err", r_err, 1);
        check("unmap_valid_seen", {r_seen_ram, r_seen_io}, 0);
        run_txn(32'h1000_0000, 4'b0000, 32'h0, 1'b1);
        check("fetch_io_cycle", r_cyc, 1);
        check("fetch_io_err", r_err, 1);
        check("fetch_io_valid_seen", {r_seen_ram, r_seen_io}, 0);
        check("err_count_2", err_count, 2);
        check("err_addr_fetch", err_addr, 32'h1000_0000);

        // RAM region edges.
        ram_word = 32'h0000_1FFC;
        run_txn(32'h0001_FFFC, 4'b0000, 32'h0, 1'b0);
        check("ram_top_cycle", r_cyc, 3);
        check("ram_top_addr", r_ram_addr, 32'h0001_FFFC);
        run_txn(32'h0002_0000, 4'b0000, 32'h0, 1'b0);
        check("ram_end_err", r_err, 1);
        check("err_count_3", err_count, 3);

        // IO timeout, then ready on the final ACCESS cycle.
        io_lat = -1;
        run_txn(32'h1000_0008, 4'b0000, 32'h0, 1'b0);
        check("tmo_cycle", r_cyc, 17);
        check("tmo_err", r_err, 1);
        check("tmo_data", r_rdata, 32'h0);
        check("tmo_io_valid_drop", io_valid, 0);
        check("tmo_err_addr", err_addr, 32'h1000_0008);
        check("tmo_err_count", err_count, 4);
        io_lat = 15;
        run_txn(32'h1000_0008, 4'b0000, 32'h0, 1'b0);
        check("late_rdy_cycle", r_cyc, 17);
        check("late_rdy_err", r_err, 0);
        check("late_rdy_data", r_rdata, 32'hCAFE_0004);

        // Reset in the middle of a RAM write.
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0000_0040;
        cpu_mem_wstrb = 4'b1111;
        cpu_mem_wdata = 32'h0000_0055;
        step();
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = '0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;
        check("mid_access_valid", ram_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_ready", cpu_mem_ready, 0);
        check("mrst_ram_valid", ram_valid, 0);
        check("mrst_ram_en", ram_enable, 0);
        check("mrst_ram_wstrb", ram_wstrb, 0);
        check("mrst_io_valid", io_valid, 0);
        check("mrst_bus_error", bus_error, 0);
        check("mrst_err_count", err_count, 0);
        check("mrst_err_addr", err_addr, 0);
        check("mrst_rdata", cpu_mem_rdata, 0);
        check("mrst_ram_addr", ram_addr, 0);
        check("mrst_ram_wdata", ram_wdata, 0);
        check("mrst_io_addr", io_addr, 32'hF000_0000);
        repeat (2) step();

        ram_word = 32'h1234_5678;
        run_txn(32'h0000_0010, 4'b0000, 32'h0, 1'b0);
        check("post_rst_cycle", r_cyc, 3);
        check("post_rst_data", r_rdata, 32'h1234_5678);
        check("post_rst_err", r_err, 0);
        check("total_strb_cycles", wstrb_nz_cycles, 3);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) run_txn(32'h8000_0000, 4'b0000, 32'h0, 1'b0);
        check("err_count_sat", err_count, 255);
        check("sat_err_addr", err_addr, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
